// File: rtl/sram_controller_if.sv
// sram_controller_if: request/response bus between the SRAM arbiter (master)
// and the SRAM controller (slave).
//   req_valid/req_ready  - request handshake (transfer on valid && ready at clk edge)
//   req_we               - 1 = write, 0 = read
//   req_addr, req_wdata  - request address / write data
//   rsp_valid, rsp_rdata - one-cycle read response pulse and read data
//   wr_done              - one-cycle pulse when a write strobe has completed
interface sram_controller_if #(
   parameter int aw = 19,
   parameter int dw = 8
);
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [aw-1:0] req_addr;
   logic [dw-1:0] req_wdata;
   logic          rsp_valid;
   logic [dw-1:0] rsp_rdata;
   logic          wr_done;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, wr_done
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, wr_done
   );
endinterface

// File: rtl/sram_controller.sv
// sram_controller: initiator-side controller for an external SRAM port.
// Accepts single-word read/write requests, sequences ce_n/oe_n/we_n and owns
// the dq tristate.
//   clk, rst   - clock; synchronous active-high reset
//   bus        - request/response interface (slave side)
//   sram_addr  - SRAM address, holds the last transaction's address in IDLE
//   sram_ce_n  - chip enable, active-low
//   sram_oe_n  - output enable, active-low
//   sram_we_n  - write enable, active-low
//   sram_dq    - bidirectional data bus, driven only while sram_we_n is low
module sram_controller #(
   parameter int aw           = 19,
   parameter int dw           = 8,
   parameter int read_latency = 2
) (
   input  logic              clk,
   input  logic              rst,
   sram_controller_if.slave  bus,
   output logic [aw-1:0]     sram_addr,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   inout  wire  [dw-1:0]     sram_dq
);
   localparam int CW = $clog2(read_latency + 2);

   typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

   state_t        r_state,     w_state_nx;
   logic [aw-1:0] r_addr,      w_addr_nx;
   logic [dw-1:0] r_wdata,     w_wdata_nx;
   logic [dw-1:0] r_rdata,     w_rdata_nx;
   logic [CW-1:0] r_cnt,       w_cnt_nx;
   logic          r_ce_n,      w_ce_n_nx;
   logic          r_oe_n,      w_oe_n_nx;
   logic          r_we_n,      w_we_n_nx;
   logic          r_dq_oe,     w_dq_oe_nx;
   logic          r_rsp_valid, w_rsp_valid_nx;
   logic          r_wr_done,   w_wr_done_nx;
   logic          w_ready;
   logic          w_hs;

   assign w_ready = (r_state == IDLE) && !rst;
   assign w_hs    = bus.req_valid && w_ready;

   always_comb begin
      w_state_nx     = r_state;
      w_addr_nx      = r_addr;
      w_wdata_nx     = r_wdata;
      w_rdata_nx     = r_rdata;
      w_cnt_nx       = r_cnt;
      w_ce_n_nx      = r_ce_n;
      w_oe_n_nx      = r_oe_n;
      w_we_n_nx      = r_we_n;
      w_dq_oe_nx     = r_dq_oe;
      w_rsp_valid_nx = 1'b0;
      w_wr_done_nx   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_hs) begin
               w_addr_nx = bus.req_addr;
               w_ce_n_nx = 1'b0;
               if (bus.req_we) begin
                  w_wdata_nx = bus.req_wdata;
                  w_we_n_nx  = 1'b0;
                  w_oe_n_nx  = 1'b1;
                  w_dq_oe_nx = 1'b1;
                  w_state_nx = WRITE;
               end else begin
                  w_cnt_nx   = '0;
                  w_we_n_nx  = 1'b1;
                  w_oe_n_nx  = 1'b0;
                  w_dq_oe_nx = 1'b0;
                  w_state_nx = READ;
               end
            end
         end
         WRITE: begin
            // The device samples dq on this closing edge; release the bus on
            // the same edge that raises we_n.
            w_we_n_nx    = 1'b1;
            w_ce_n_nx    = 1'b1;
            w_dq_oe_nx   = 1'b0;
            w_wr_done_nx = 1'b1;
            w_state_nx   = IDLE;
         end
         READ: begin
            w_cnt_nx = r_cnt + 1'b1;
            // Counter is 0 after the entry edge, so reaching read_latency
            // here means this is the (read_latency+1)-th edge after entry.
            if (r_cnt == CW'(read_latency)) begin
               w_rdata_nx     = sram_dq;
               w_rsp_valid_nx = 1'b1;
               w_ce_n_nx      = 1'b1;
               w_oe_n_nx      = 1'b1;
               w_state_nx     = IDLE;
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rdata     <= '0;
         r_cnt       <= '0;
         r_ce_n      <= 1'b1;
         r_oe_n      <= 1'b1;
         r_we_n      <= 1'b1;
         r_dq_oe     <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_wr_done   <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_addr      <= w_addr_nx;
         r_wdata     <= w_wdata_nx;
         r_rdata     <= w_rdata_nx;
         r_cnt       <= w_cnt_nx;
         r_ce_n      <= w_ce_n_nx;
         r_oe_n      <= w_oe_n_nx;
         r_we_n      <= w_we_n_nx;
         r_dq_oe     <= w_dq_oe_nx;
         r_rsp_valid <= w_rsp_valid_nx;
         r_wr_done   <= w_wr_done_nx;
      end
   end

   assign bus.req_ready = w_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rdata;
   assign bus.wr_done   = r_wr_done;

   assign sram_addr = r_addr;
   assign sram_ce_n = r_ce_n;
   assign sram_oe_n = r_oe_n;
   assign sram_we_n = r_we_n;
   assign sram_dq   = r_dq_oe ? r_wdata : 'z;
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: self-checking bench for sram_controller with a
// behavioural SRAM device (two-stage read pipeline, write on clock edge while
// we_n low, dq driven by the device whenever we_n is high) and a scoreboard.
module tb_sram_controller;
   localparam int AW = 19;
   localparam int DW = 8;
   localparam int RL = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] sram_addr;
   logic          sram_ce_n, sram_oe_n, sram_we_n;
   wire  [DW-1:0] sram_dq;

   sram_controller_if #(.aw(AW), .dw(DW)) bus ();

   sram_controller #(.aw(AW), .dw(DW), .read_latency(RL)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .sram_addr (sram_addr),
      .sram_ce_n (sram_ce_n),
      .sram_oe_n (sram_oe_n),
      .sram_we_n (sram_we_n),
      .sram_dq   (sram_dq)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural SRAM device ----------------
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] dev_p1 = '0;
   logic [DW-1:0] dev_p2 = '0;

   initial for (int i = 0; i < (1 << AW); i++) mem[i] = i[7:0];

   always @(posedge clk) begin
      dev_p1 <= mem[sram_addr];
      dev_p2 <= dev_p1;
      if (!sram_ce_n && !sram_we_n) mem[sram_addr] <= sram_dq;
   end

   assign sram_dq = sram_we_n ? dev_p2 : 'z;

   // ---------------- reference model and scoreboard ----------------
   typedef struct {
      bit            is_rd;
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] ref_mem [int];
   logic [DW-1:0] last_wdata = '0;
   int            cyc = 0;
   int            n_tests = 0;
   int            n_fail = 0;
   bit            chk_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
      if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
      return a[7:0];
   endfunction

   // Monitor: pops the scoreboard whenever the DUT presents a response, and
   // watches bus ownership every cycle.
   exp_t mon_e;
   always @(negedge clk) begin
      if (chk_en) begin
         if (bus.rsp_valid && bus.wr_done) check("pulse_overlap", 1, 0);
         if (bus.rsp_valid || bus.wr_done) begin
            if (sb.size() == 0) begin
               check("unexpected_response", 1, 0);
            end else begin
               mon_e = sb.pop_front();
               check("rsp_kind", {31'd0, bus.rsp_valid}, {31'd0, mon_e.is_rd});
               if (mon_e.is_rd) check("rsp_rdata", {24'd0, bus.rsp_rdata}, {24'd0, mon_e.data});
               check("rsp_latency", cyc, mon_e.due);
            end
         end
         if (sram_we_n) check("dq_device_owned", {24'd0, sram_dq}, {24'd0, dev_p2});
         else           check("dq_write_data",   {24'd0, sram_dq}, {24'd0, last_wdata});
      end
   end

   // Called just after a negedge; returns 1 time unit after the handshake edge
   // with req_valid still asserted.
   task automatic issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int hs);
      exp_t e;
      bit   got = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = a;
      bus.req_wdata = d;
      hs = -1;
      for (int b = 0; b < 50 && !got; b++) begin
         #1;
         if (bus.req_ready) begin
            got = 1'b1;
            hs  = cyc + 1;
            e.is_rd = !we;
            if (we) begin
               ref_mem[int'(a)] = d;
               last_wdata = d;
               e.data = d;
               e.due  = hs + 1;
            end else begin
               e.data = ref_read(a);
               e.due  = hs + RL + 1;
            end
            sb.push_back(e);
            @(posedge clk);
            #1;
         end else begin
            @(negedge clk);
         end
      end
      if (!got) check("handshake_timeout", 0, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int            hs1, hs2, hs3;
      logic [AW-1:0] a;
      bit            we;

      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ce_n", sram_ce_n, 1);
      check("rst_oe_n", sram_oe_n, 1);
      check("rst_we_n", sram_we_n, 1);
      check("rst_addr", sram_addr, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rdata", bus.rsp_rdata, 0);
      check("rst_wr_done", bus.wr_done, 0);
      check("rst_ready", bus.req_ready, 0);
      rst = 1'b0;
      chk_en = 1'b1;
      #1 check("ready_after_rst", bus.req_ready, 1);

      // Idle for 20 cycles
      repeat (20) begin
         @(negedge clk);
         check("idle_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
         check("idle_ready", bus.req_ready, 1);
      end

      // Read of preloaded address, oe_n low for the whole read
      @(negedge clk);
      issue(1'b0, 19'h00003, 8'h00, hs1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         bus.req_valid = 1'b0;
         check("read_oe_low", sram_oe_n, 0);
      end
      @(negedge clk);
      check("read_oe_high_after", sram_oe_n, 1);

      // Write then read back
      issue(1'b1, 19'h00010, 8'hA5, hs1);
      @(negedge clk);
      bus.req_valid = 1'b0;
      issue(1'b0, 19'h00010, 8'h00, hs1);
      @(negedge clk);
      bus.req_valid = 1'b0;

      // Back-to-back with req_valid held
      issue(1'b1, 19'h7FFFF, 8'h5A, hs1);
      @(negedge clk);
      issue(1'b0, 19'h7FFFF, 8'h00, hs2);
      @(negedge clk);
      issue(1'b0, 19'h00000, 8'h00, hs3);
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("b2b_write_gap", hs2 - hs1, 2);
      check("b2b_read_gap", hs3 - hs2, RL + 2);

      // Requests offered while busy are ignored
      issue(1'b0, 19'h00055, 8'h00, hs1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("busy_ready_low", bus.req_ready, 0);
         check("busy_addr_stable", sram_addr, 19'h00055);
         bus.req_valid = 1'($urandom_range(0, 1));
         bus.req_we    = 1'($urandom_range(0, 1));
         bus.req_addr  = 19'($urandom);
      end
      @(negedge clk);
      bus.req_valid = 1'b0;

      // Reset during the second READ cycle
      @(negedge clk);
      issue(1'b0, 19'h00040, 8'h00, hs1);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      void'(sb.pop_back());
      @(negedge clk);
      check("abort_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
      check("abort_rsp_valid", bus.rsp_valid, 0);
      check("abort_ready_in_rst", bus.req_ready, 0);
      rst = 1'b0;
      #1 check("abort_ready_after", bus.req_ready, 1);
      issue(1'b0, 19'h00004, 8'h00, hs1);
      @(negedge clk);
      bus.req_valid = 1'b0;

      // Randomised traffic against the reference model
      repeat (60) begin
         we = 1'($urandom_range(0, 1));
         a  = ($urandom_range(0, 3) == 0) ? 19'($urandom) : 19'($urandom_range(0, 15));
         issue(we, a, 8'($urandom), hs1);
         repeat ($urandom_range(1, 3)) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
         end
      end

      repeat (10) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/sram_controller.md
# sram_controller

Initiator-side controller for the external asynchronous-style SRAM port (addr, ce_n, oe_n, we_n, bidirectional dq). It accepts single-word read/write requests over a valid/ready interface, sequences the SRAM control strobes and owns the dq tristate. Read data is returned with a one-cycle response pulse. It sits between the SRAM arbiter and the SRAM pins, and is verified against the SRAM behavioural model: two-stage read pipeline, writes sampled on the clock edge while we_n is low, dq driven by the device whenever we_n is high.

## Interface
- aw, 19, address width
- dw, 8, data width
- read_latency, 2, device read pipeline depth in clocks (edges from address valid to dq valid); must be ≥1
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  aw  request address
- req_wdata  in  dw  write data
- rsp_valid  out  1  one-cycle pulse: rsp_rdata valid (reads only)
- rsp_rdata  out  dw  read data
- wr_done  out  1  one-cycle pulse: write strobe completed
- sram_addr  out  aw  SRAM address
- sram_ce_n  out  1  chip enable, active-low
- sram_oe_n  out  1  output enable, active-low
- sram_we_n  out  1  write enable, active-low
- sram_dq  inout  dw  SRAM data bus

## Operation
- States: IDLE, WRITE, READ.
- req_ready = (state == IDLE) && !rst. A handshake is req_valid && req_ready at a rising edge.
- IDLE, write accepted: latch addr and wdata, go to WRITE; registered outputs become sram_ce_n=0, sram_we_n=0, sram_oe_n=1, dq output enable=1.
- WRITE: lasts exactly 1 cycle; the device samples dq at the closing edge. At that edge:
  - go to IDLE;
  - sram_we_n=1, sram_ce_n=1, dq output enable=0;
  - wr_done=1 for one cycle.
- IDLE, read accepted: latch addr, clear counter, go to READ; sram_ce_n=0, sram_oe_n=0, sram_we_n=1, dq tristated.
- READ:
  - counter increments each edge;
  - at the (read_latency+1)-th edge after entry, capture sram_dq into rsp_rdata, pulse rsp_valid, go to IDLE, sram_ce_n=1, sram_oe_n=1.
- sram_addr holds the latched address for the whole transaction and keeps its last value in IDLE.
- dq is driven only while sram_we_n is low. dq output enable and sram_we_n come from registers updated on the same edge, so the bus is never driven by both ends.
- rsp_rdata holds its last value between responses.
- Counter width: clog2(read_latency+2).
- No queuing. Requests offered while req_ready=0 are ignored; the requester must hold them.

## Timing
- Reset values:
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1, dq tristated;
  - sram_addr=0;
  - rsp_valid=0, rsp_rdata=0, wr_done=0;
  - req_ready=0 while rst=1;
  - state=IDLE.
- Write: handshake at edge E0; sram_we_n low during E0–E1; wr_done high during E1–E2; req_ready high again after E1. Throughput is one write every 2 cycles.
- Read, read_latency=2: handshake at E0; device loads its pipeline at E1; dq valid after E2; captured at E3; rsp_valid high during E3–E4; req_ready high after E3. Throughput is one read every read_latency+2 cycles.
- Read after write and write after read need no extra turnaround cycle. IDLE between them guarantees we_n transitions separate bus ownership.
- Reset mid-transaction: return to IDLE at that edge. No rsp_valid or wr_done for the aborted request. A write in progress is not guaranteed to have landed.
- rsp_valid and wr_done are never high in the same cycle.

## Test plan
- Model 0 preload (mem[i]=i[7:0]): read 0x00003 → rsp_valid exactly 3 cycles after the handshake, rsp_rdata=0x03; sram_oe_n low for those 3 cycles.
- Write 0xA5 to 0x00010, then read 0x00010 → wr_done 1 cycle after the write handshake; read returns 0xA5; sram_dq never X/contended (checker: we_n high ⇒ controller not driving).
- Back-to-back with req_valid held high, sequence W(0x7FFFF,0x5A), R(0x7FFFF), R(0x00000) → handshakes at cycles 0, 2, 6; responses 0x5A then 0x00; req_ready low in every intervening cycle.
- req_valid pulsed while busy (during READ), with addr changing → ignored; sram_addr stays stable; a single rsp_valid for the original request.
- Assert rst during READ cycle 2 → next cycle all strobes high, dq tristated, no rsp_valid; the following read of 0x00004 returns 0x04.
- Idle after reset with req_valid=0 for 20 cycles → strobes all 1, rsp_valid/wr_done stay 0, req_ready=1 from the first cycle after reset.
